// File: rtl/eth_pkg.sv
// ============================================================================
// Module  : eth_pkg
// Brief   : Shared types and constants for the Ethernet frame transmit path.
//           The optional TX_PAD state exists only when ETH_TX_PAD_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package eth_pkg;

  // The MAC header is 3.5 words, so payload lands 16 bits off word alignment.
  localparam int ETH_HDR_BYTES = 14;
  localparam int ETH_MIN_FRAME = 60;

  typedef logic [47:0] mac_addr_t;
  typedef logic [15:0] ethertype_t;

  typedef enum logic [2:0] {
    TX_IDLE = 3'd0,
    TX_HDR0 = 3'd1,
    TX_HDR1 = 3'd2,
    TX_HDR2 = 3'd3,
    TX_BODY = 3'd4,
    TX_TAIL = 3'd5
`ifdef ETH_TX_PAD_EN
    , TX_PAD = 3'd6
`endif
  } tx_state_t;

  // Keep only the valid (MSB-aligned) bytes of a final payload word.
  // nb is valid bytes minus 1.
  function automatic logic [31:0] last_mask(input logic [1:0] nb);
    case (nb)
      2'd0:    return 32'hFF00_0000;
      2'd1:    return 32'hFFFF_0000;
      2'd2:    return 32'hFFFF_FF00;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/eth_frame_tx.sv
// ============================================================================
// Module  : eth_frame_tx
// Brief   : Ethernet frame transmitter. Prepends dst MAC, src MAC and
//           ethertype to a 32-bit big-endian payload stream, realigning the
//           payload by 16 bits through a carry register.
//           Optional macro ETH_TX_PAD_EN: zero-pad frames to MIN_FRAME bytes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module eth_frame_tx
  import eth_pkg::*;
#(
  parameter int CNT_W = 11
`ifdef ETH_TX_PAD_EN
  , parameter int MIN_FRAME = ETH_MIN_FRAME
`endif
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        start,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic [15:0] ethertype,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  input  logic [1:0]  in_bytes,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sop,
  output logic        out_eop,
  output logic [1:0]  out_bytes,
  output logic        busy
);

  tx_state_t        state, state_n;
  mac_addr_t        dst_r, src_r;
  ethertype_t       type_r;
  logic [15:0]      carry;
  logic [1:0]       last_bytes;
  logic [CNT_W-1:0] byte_cnt;

  logic             load;
  logic             start_ok;
  logic [31:0]      pay;

  // Next output word, produced by the FSM when the output register may load.
  logic             emit;
  logic             drop;
  logic [31:0]      emit_data;
  logic             emit_sop;
  logic             emit_eop;
  logic [1:0]       emit_bytes;
  logic [2:0]       emit_inc;
  logic             carry_we;
  logic [15:0]      carry_n;
  logic             lb_we;

  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] cnt_next;

  assign load     = !out_valid || out_ready;
  // busy stays high while the eop word waits, so a new start waits for it.
  assign start_ok = (state == TX_IDLE) && start && !busy;
  assign in_ready = (state == TX_BODY) && load && !clear;
  assign pay      = in_last ? (in_data & last_mask(in_bytes)) : in_data;

  // Saturating frame byte count.
  assign cnt_sum  = {1'b0, byte_cnt} + {{(CNT_W-2){1'b0}}, emit_inc};
  assign cnt_next = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= TX_IDLE;
    end else if (clear) begin
      state <= TX_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and next output word.
  always_comb begin
    state_n    = state;
    emit       = 1'b0;
    drop       = 1'b0;
    emit_data  = 32'h0;
    emit_sop   = 1'b0;
    emit_eop   = 1'b0;
    emit_bytes = 2'd3;
    emit_inc   = 3'd4;
    carry_we   = 1'b0;
    carry_n    = 16'h0;
    lb_we      = 1'b0;
    case (state)
      TX_IDLE: begin
        drop = load;
        if (start_ok) state_n = TX_HDR0;
      end
      TX_HDR0: if (load) begin
        emit      = 1'b1;
        emit_data = dst_r[47:16];
        emit_sop  = 1'b1;
        state_n   = TX_HDR1;
      end
      TX_HDR1: if (load) begin
        emit      = 1'b1;
        emit_data = {dst_r[15:0], src_r[47:32]};
        state_n   = TX_HDR2;
      end
      TX_HDR2: if (load) begin
        emit      = 1'b1;
        emit_data = src_r[31:0];
        carry_we  = 1'b1;
        carry_n   = type_r;
        state_n   = TX_BODY;
      end
      TX_BODY: if (load) begin
        if (in_valid) begin
          emit      = 1'b1;
          emit_data = {carry, pay[31:16]};
          carry_we  = 1'b1;
          carry_n   = pay[15:0];
          if (in_last) begin
            if (!in_bytes[1]) begin
              // 1-2 final bytes fit beside the carry: this word ends the frame.
              emit_eop   = 1'b1;
              emit_bytes = 2'(in_bytes + 2'd2);
              emit_inc   = 3'({1'b0, in_bytes} + 3'd3);
              state_n    = TX_IDLE;
`ifdef ETH_TX_PAD_EN
              if ((int'(byte_cnt) + int'(emit_inc)) < MIN_FRAME) begin
                emit_bytes = 2'd3;
                emit_inc   = 3'd4;
                if ((int'(byte_cnt) + 4) < MIN_FRAME) begin
                  emit_eop = 1'b0;
                  state_n  = TX_PAD;
                end
              end
`endif
            end else begin
              // 3-4 final bytes spill two bytes into a trailing word.
              lb_we   = 1'b1;
              state_n = TX_TAIL;
            end
          end
        end else begin
          drop = 1'b1;
        end
      end
      TX_TAIL: if (load) begin
        emit       = 1'b1;
        emit_data  = {carry, 16'h0};
        emit_eop   = 1'b1;
        emit_bytes = 2'(last_bytes - 2'd2);
        emit_inc   = 3'({1'b0, last_bytes} - 3'd1);
        state_n    = TX_IDLE;
`ifdef ETH_TX_PAD_EN
        if ((int'(byte_cnt) + int'(emit_inc)) < MIN_FRAME) begin
          emit_bytes = 2'd3;
          emit_inc   = 3'd4;
          if ((int'(byte_cnt) + 4) < MIN_FRAME) begin
            emit_eop = 1'b0;
            state_n  = TX_PAD;
          end
        end
`endif
      end
`ifdef ETH_TX_PAD_EN
      TX_PAD: if (load) begin
        emit      = 1'b1;
        emit_data = 32'h0;
        if ((int'(byte_cnt) + 4) >= MIN_FRAME) begin
          emit_eop = 1'b1;
          state_n  = TX_IDLE;
        end
      end
`endif
      default: state_n = TX_IDLE;
    endcase
  end

  // Output register, config latch, carry and byte counter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_data   <= 32'h0;
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_bytes  <= 2'd3;
      busy       <= 1'b0;
      carry      <= 16'h0;
      last_bytes <= 2'd0;
      byte_cnt   <= '0;
      dst_r      <= '0;
      src_r      <= '0;
      type_r     <= '0;
    end else if (clear) begin
      out_data   <= 32'h0;
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_bytes  <= 2'd3;
      busy       <= 1'b0;
      carry      <= 16'h0;
      byte_cnt   <= '0;
    end else begin
      if (start_ok) begin
        dst_r    <= dst_mac;
        src_r    <= src_mac;
        type_r   <= ethertype;
        busy     <= 1'b1;
        byte_cnt <= '0;
      end else if (out_valid && out_ready && out_eop) begin
        busy <= 1'b0;
      end
      if (emit) begin
        out_data  <= emit_data;
        out_valid <= 1'b1;
        out_sop   <= emit_sop;
        out_eop   <= emit_eop;
        out_bytes <= emit_bytes;
        byte_cnt  <= cnt_next;
      end else if (drop) begin
        out_valid <= 1'b0;
        out_sop   <= 1'b0;
        out_eop   <= 1'b0;
      end
      if (carry_we) carry <= carry_n;
      if (lb_we) last_bytes <= in_bytes;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_eth_frame_tx.sv
// ============================================================================
// Module  : tb_eth_frame_tx
// Brief   : Directed self-checking bench for eth_frame_tx. Expected frames
//           are hand-written word lists; padding is appended when the design
//           is built with ETH_TX_PAD_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_eth_frame_tx;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [47:0] dst_mac = 48'h1122_3344_5566;
  logic [47:0] src_mac = 48'hAABB_CCDD_EEFF;
  logic [15:0] ethertype = 16'h0800;
  logic [31:0] in_data = 32'h0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [1:0]  in_bytes = 2'd0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_sop;
  logic        out_eop;
  logic [1:0]  out_bytes;
  logic        busy;

  eth_frame_tx dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .start(start),
    .dst_mac(dst_mac), .src_mac(src_mac), .ethertype(ethertype),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_bytes(in_bytes), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .out_bytes(out_bytes), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        sop;
    logic        eop;
    logic [1:0]  b;
  } word_t;

  int          tests = 0;
  int          fails = 0;
  word_t       got[$];
  word_t       exp[$];
  logic [31:0] pay[0:7];
  int          npay;
  int          stall_err;

  // Drive one frame: start, payload words, optional out_ready toggling,
  // optional start during BODY, optional clear after clear_at words.
  task automatic run_frame(input bit bp, input bit start_mid, input int clear_at,
                           output bit timeout);
    int p;
    bit done, did, accept_in, prev_stall;
    logic [31:0] prev_d;
    p = 0; done = 0; did = 0; prev_stall = 0; prev_d = 32'h0;
    got.delete();
    stall_err = 0;
    timeout = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    in_valid = 1'b1; in_data = pay[0]; in_last = (npay == 1);
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (prev_stall && out_data !== prev_d) stall_err++;
      if (out_valid && !out_ready && in_ready) stall_err++;
      prev_stall = out_valid && !out_ready;
      prev_d = out_data;
      accept_in = in_valid && in_ready;
      if (out_valid && out_ready) begin
        got.push_back({out_data, out_sop, out_eop, out_bytes});
        if (out_eop) done = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (accept_in) p++;
      in_valid = (p < npay);
      in_data  = (p < npay) ? pay[p] : 32'h0;
      in_last  = (p == npay - 1);
      if (start_mid && !did && p == 1) begin
        start = 1'b1;
        did = 1'b1;
      end
      if (bp) out_ready = !out_ready;
      if (clear_at != 0 && got.size() >= clear_at) begin
        clear = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1 clear = 1'b0;
        timeout = 1'b0;
        break;
      end
      if (done) begin
        timeout = 1'b0;
        break;
      end
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
  endtask

  // Padded builds turn the eop word into a full word and fill to 60 bytes.
  task automatic add_pad();
`ifdef ETH_TX_PAD_EN
    word_t w;
    w = exp.pop_back();
    w.eop = 1'b0; w.b = 2'd3;
    exp.push_back(w);
    while (exp.size() < 14) exp.push_back({32'h0, 1'b0, 1'b0, 2'd3});
    exp.push_back({32'h0, 1'b0, 1'b1, 2'd3});
`endif
  endtask

  task automatic set_basic();
    npay = 2; pay[0] = 32'hDEAD_BEEF; pay[1] = 32'h0102_0304; in_bytes = 2'd3;
    exp.delete();
    exp.push_back({32'h1122_3344, 1'b1, 1'b0, 2'd3});
    exp.push_back({32'h5566_AABB, 1'b0, 1'b0, 2'd3});
    exp.push_back({32'hCCDD_EEFF, 1'b0, 1'b0, 2'd3});
    exp.push_back({32'h0800_DEAD, 1'b0, 1'b0, 2'd3});
    exp.push_back({32'hBEEF_0102, 1'b0, 1'b0, 2'd3});
    exp.push_back({32'h0304_0000, 1'b0, 1'b1, 2'd1});
    add_pad();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (out_data !== 32'h0) begin fails++; $display("FAIL reset_data got %h want 0", out_data); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", out_valid); end
    tests++; if (out_sop !== 1'b0) begin fails++; $display("FAIL reset_sop got %b want 0", out_sop); end
    tests++; if (out_eop !== 1'b0) begin fails++; $display("FAIL reset_eop got %b want 0", out_eop); end
    tests++; if (out_bytes !== 2'd3) begin fails++; $display("FAIL reset_bytes got %0d want 3", out_bytes); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    @(posedge clk); #1 n_rst = 1'b1;
  endtask

  task automatic test_basic();
    bit to;
    set_basic();
    run_frame(1'b0, 1'b0, 0, to);
    tests++; if (to) begin fails++; $display("FAIL basic_timeout got no eop want eop"); end
    tests++;
    if (got.size() !== exp.size()) begin
      fails++; $display("FAIL basic_len got %0d want %0d", got.size(), exp.size());
    end else foreach (exp[i]) begin
      tests++;
      if (got[i] !== exp[i]) begin fails++; $display("FAIL basic_word%0d got %h want %h", i, got[i], exp[i]); end
    end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_after got %b want 0", busy); end
  endtask

  task automatic test_short();
    bit to;
    npay = 1; pay[0] = 32'hCAFE_0000; in_bytes = 2'd1;
    exp.delete();
    exp.push_back({32'h1122_3344, 1'b1, 1'b0, 2'd3});
    exp.push_back({32'h5566_AABB, 1'b0, 1'b0, 2'd3});
    exp.push_back({32'hCCDD_EEFF, 1'b0, 1'b0, 2'd3});
    exp.push_back({32'h0800_CAFE, 1'b0, 1'b1, 2'd3});
    add_pad();
    run_frame(1'b0, 1'b0, 0, to);
    tests++; if (to) begin fails++; $display("FAIL short_timeout got no eop want eop"); end
    tests++;
    if (got.size() !== exp.size()) begin
      fails++; $display("FAIL short_len got %0d want %0d", got.size(), exp.size());
    end else foreach (exp[i]) begin
      tests++;
      if (got[i] !== exp[i]) begin fails++; $display("FAIL short_word%0d got %h want %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    set_basic();
    run_frame(1'b1, 1'b0, 0, to);
    tests++; if (to) begin fails++; $display("FAIL bp_timeout got no eop want eop"); end
    tests++;
    if (got.size() !== exp.size()) begin
      fails++; $display("FAIL bp_len got %0d want %0d", got.size(), exp.size());
    end else foreach (exp[i]) begin
      tests++;
      if (got[i] !== exp[i]) begin fails++; $display("FAIL bp_word%0d got %h want %h", i, got[i], exp[i]); end
    end
    tests++; if (stall_err !== 0) begin fails++; $display("FAIL bp_stall got %0d violations want 0", stall_err); end
  endtask

  task automatic test_clear();
    bit to;
    set_basic();
    run_frame(1'b0, 1'b0, 4, to);
    tests++; if (to) begin fails++; $display("FAIL clear_timeout got no clear point want 4 words"); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL clear_valid got %b want 0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL clear_busy got %b want 0", busy); end
    tests++;
    if (got.size() < 4 || got[3].d !== 32'h0800_DEAD) begin
      fails++; $display("FAIL clear_word3 got size %0d want 0800dead at word 3", got.size());
    end
    run_frame(1'b0, 1'b0, 0, to);
    tests++;
    if (to || got.size() !== exp.size() || got[0] !== exp[0]) begin
      fails++; $display("FAIL clear_restart got %0d words want %0d with first %h", got.size(), exp.size(), exp[0]);
    end
  endtask

  task automatic test_start_busy();
    bit to;
    set_basic();
    run_frame(1'b0, 1'b1, 0, to);
    tests++; if (to) begin fails++; $display("FAIL start_busy_timeout got no eop want eop"); end
    tests++;
    if (got.size() !== exp.size()) begin
      fails++; $display("FAIL start_busy_len got %0d want %0d", got.size(), exp.size());
    end else foreach (exp[i]) begin
      tests++;
      if (got[i] !== exp[i]) begin fails++; $display("FAIL start_busy_word%0d got %h want %h", i, got[i], exp[i]); end
    end
    @(negedge clk);
    tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL start_busy_idle got busy %b valid %b want 0 0", busy, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short();
    test_backpressure();
    test_clear();
    test_start_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/eth_frame_tx.md
Name: eth_frame_tx

Overview:
Ethernet frame transmitter: prepends a 14-byte MAC header (dst MAC, src MAC, ethertype) to a payload word stream and emits the frame as a 32-bit big-endian word stream. It is the producer-side counterpart of the MAC match comparators and drives the same 32-bit datapath format. Used to inject test frames and responses from the Atom-programmed configuration. Payload is realigned by 16 bits because the header is 3.5 words.

Parameters:
CNT_W, 11, width of frame byte counter (saturating)
MIN_FRAME, 60, minimum frame bytes excluding FCS (used only with padding feature)

Ports:
clk  in  1  clock
n_rst  in  1  reset, asynchronous, active-low
clear  in  1  synchronous abort: return to IDLE, drop out_valid
start  in  1  begin frame; honoured only in IDLE
dst_mac  in  48  destination MAC, sampled on accepted start
src_mac  in  48  source MAC, sampled on accepted start
ethertype  in  16  type/length, sampled on accepted start
in_data  in  32  payload word, byte 0 at [31:24]
in_valid  in  1  payload word valid
in_last  in  1  final payload word
in_bytes  in  2  valid bytes minus 1 on in_last word (MSB-aligned); ignored otherwise
in_ready  out  1  payload word accepted when in_valid & in_ready
out_data  out  32  frame word, byte 0 at [31:24], unused bytes zero
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts when out_valid & out_ready
out_sop  out  1  first word of frame
out_eop  out  1  last word of frame
out_bytes  out  2  valid bytes minus 1; meaningful with out_eop, else 3
busy  out  1  high from accepted start until eop word accepted

Behaviour:
- Reset (n_rst low) or clear: state IDLE; out_data 0, out_valid 0, out_sop 0, out_eop 0, out_bytes 3, busy 0, in_ready 0, carry 0, byte count 0. Clear has priority over all other events.
- Output register advances when load = !out_valid | out_ready. Without load, all outputs hold stable.
- States: IDLE, HDR0, HDR1, HDR2, BODY, TAIL.
- IDLE: start latches config, busy=1 -> HDR0. Start in any other state ignored.
- HDR0 on load: out = dst[47:16], sop=1 -> HDR1.
- HDR1 on load: out = {dst[15:0], src[47:32]} -> HDR2.
- HDR2 on load: out = src[31:0]; carry <= ethertype -> BODY.
- BODY: in_ready = load. On accept: out = {carry, in_data[31:16]}; carry <= in_data[15:0].
  - Non-last: stay in BODY.
  - Last with in_bytes 0/1 (1-2 bytes): this word is eop, out_bytes = in_bytes+2, -> IDLE.
  - Last with in_bytes 2/3: full word, not eop, -> TAIL.
- TAIL on load: out = {carry, 16'h0}, eop=1, out_bytes = in_bytes_latched-2 -> IDLE.
- If load is true but no word is ready (BODY with !in_valid), out_valid goes 0. No bubbles are inserted otherwise: throughput is 1 word/cycle when in_valid & out_ready.
- First frame word is available 1 cycle after start. Back-to-back frames: start accepted the cycle after the eop word is accepted (busy=0).
- busy clears in the cycle the eop word is accepted.
- Byte counter counts emitted valid bytes and saturates at 2^CNT_W-1.
- Mid-frame n_rst/clear: the partial frame is discarded with no eop; the downstream must treat a missing eop as abort.

Optional Feature:
ETH_TX_PAD_EN: when defined, frames shorter than MIN_FRAME bytes are zero-padded.
- The final payload word is emitted as a non-eop word, with unused bytes zero counted as valid.
- A PAD state then emits 32'h0 words until the byte count reaches MIN_FRAME. The last of these has eop=1 and out_bytes=3.
- Frames of at least MIN_FRAME bytes are unaffected.
- When undefined: no PAD state; short frames are emitted unpadded.

Decomposition:
- Package eth_pkg: tx state enum, ETH_HDR_BYTES=14, MIN_FRAME default, MAC/ethertype typedefs (logic [47:0], logic [15:0]).
- No sub-module needed. The 16-bit realignment (carry + merge) is inline; an optional helper module eth_word_align can be split out if reused by the receive side.

Test Plan:
- Basic frame. Config: dst=0x112233445566, src=0xAABBCCDDEEFF, type=0x0800. Payload: 0xDEADBEEF, then 0x01020304 with last, in_bytes=3. Expected output: 0x11223344(sop), 0x5566AABB, 0xCCDDEEFF, 0x0800DEAD, 0xBEEF0102, 0x03040000 (eop, out_bytes=1).
- Short last word. Same config, single payload word 0xCAFE0000 with last, in_bytes=1. Expected output: 4 words, final 0x0800CAFE with eop and out_bytes=3; no TAIL word.
- Backpressure. Toggle out_ready 1010... during the basic frame. Expected: identical word sequence, out_data stable while out_valid & !out_ready, no in_ready while stalled.
- Mid-frame clear. Assert clear after the 0x0800DEAD word. Expected: next cycle out_valid=0 and busy=0; a new start emits 0x11223344 with sop.
- Start while busy. Assert start during BODY. Expected: ignored; the frame completes unchanged.
- ETH_TX_PAD_EN. Basic frame (22 bytes). Expected: after 0x03040000 (not eop), 9 zero words; 15th word eop, out_bytes=3, 60 bytes total.
